// File: rtl/time_counter.sv
// BCD 24-hour timekeeping core: divides CP down to a 1 s tick and runs a cascaded
// sec/min/hour BCD counter with parallel preset, manual adjust and registered carry pulses.
module time_counter #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       EN,
  input  logic       PE,
  input  logic [7:0] pre_hour,
  input  logic [7:0] pre_min,
  input  logic       adj_min,
  input  logic       adj_hour,
  output logic [7:0] show_hour,
  output logic [7:0] show_min,
  output logic [7:0] show_sec,
  output logic       sec_tick,
  output logic       min_carry,
  output logic       hour_chime,
  output logic       day_carry,
  output logic       load_err
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  // Returns {wrapped, next} for a packed-BCD 00..59 field.
  function automatic logic [8:0] inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 9'h100;
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    end
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  // Returns {wrapped, next} for a packed-BCD 00..23 field.
  function automatic logic [8:0] inc24(input logic [7:0] v);
    if (v == 8'h23) return 9'h100;
    if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  // Numeric compare on packed BCD is safe once every units nibble is known to be <= 9.
  function automatic logic preset_ok(input logic [7:0] h, input logic [7:0] m);
    return (h[3:0] <= 4'd9) && (m[3:0] <= 4'd9) && (m[7:4] <= 4'd5) && (h <= 8'h23);
  endfunction

  logic [PW-1:0] r_presc;
  logic [7:0]    r_hour, r_min, r_sec;
  logic          r_sec_tick, r_min_carry, r_hour_chime, r_day_carry, r_load_err;

  logic          w_tick;
  logic          w_pre_ok;
  logic [8:0]    w_sec_inc, w_min_inc, w_hour_inc;

  assign w_tick     = EN && (r_presc == PRESC_MAX);
  assign w_pre_ok   = preset_ok(pre_hour, pre_min);
  assign w_sec_inc  = inc60(r_sec);
  assign w_min_inc  = inc60(r_min);
  assign w_hour_inc = inc24(r_hour);

  always_ff @(posedge CP) begin
    if (CR) begin
      r_presc      <= '0;
      r_hour       <= 8'h00;
      r_min        <= 8'h00;
      r_sec        <= 8'h00;
      r_sec_tick   <= 1'b0;
      r_min_carry  <= 1'b0;
      r_hour_chime <= 1'b0;
      r_day_carry  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_sec_tick   <= 1'b0;
      r_min_carry  <= 1'b0;
      r_hour_chime <= 1'b0;
      r_day_carry  <= 1'b0;
      r_load_err   <= PE && !w_pre_ok;
      if (PE && w_pre_ok) begin
        r_hour  <= pre_hour;
        r_min   <= pre_min;
        r_sec   <= 8'h00;
        r_presc <= '0;
      end else begin
        // The prescaler keeps running under adjust, so a coinciding tick is lost, not delayed.
        if (EN) r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (adj_min || adj_hour) begin
          if (adj_min)  r_min  <= w_min_inc[7:0];
          if (adj_hour) r_hour <= w_hour_inc[7:0];
        end else if (w_tick) begin
          r_sec      <= w_sec_inc[7:0];
          r_sec_tick <= 1'b1;
          if (w_sec_inc[8]) begin
            r_min       <= w_min_inc[7:0];
            r_min_carry <= 1'b1;
            if (w_min_inc[8]) begin
              r_hour       <= w_hour_inc[7:0];
              r_hour_chime <= 1'b1;
              r_day_carry  <= w_hour_inc[8];
            end
          end
        end
      end
    end
  end

  assign show_hour  = r_hour;
  assign show_min   = r_min;
  assign show_sec   = r_sec;
  assign sec_tick   = r_sec_tick;
  assign min_carry  = r_min_carry;
  assign hour_chime = r_hour_chime;
  assign day_carry  = r_day_carry;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: a decimal reference model feeds a scoreboard every cycle,
// and a table of directed steps carries hand-derived checkpoints.
module tb_time_counter;

  localparam int TD = 4;

  logic       CP = 1'b0;
  logic       CR, EN, PE, adj_min, adj_hour;
  logic [7:0] pre_hour, pre_min;
  logic [7:0] show_hour, show_min, show_sec;
  logic       sec_tick, min_carry, hour_chime, day_carry, load_err;

  time_counter #(.TICK_DIV(TD)) dut (
    .CP(CP), .CR(CR), .EN(EN), .PE(PE),
    .pre_hour(pre_hour), .pre_min(pre_min),
    .adj_min(adj_min), .adj_hour(adj_hour),
    .show_hour(show_hour), .show_min(show_min), .show_sec(show_sec),
    .sec_tick(sec_tick), .min_carry(min_carry), .hour_chime(hour_chime),
    .day_carry(day_carry), .load_err(load_err)
  );

  always #5 CP = ~CP;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, kept in plain decimal.
  int         mh = 0, mm = 0, ms = 0, mp = 0;
  logic [4:0] mpul = '0;   // {sec_tick, min_carry, hour_chime, day_carry, load_err}

  logic [28:0] sb[$];

  typedef struct {
    logic       cr, en, pe;
    logic [7:0] ph, pm;
    logic       am, ah;
    int         n;
    logic [7:0] eh, em, es;
    logic [4:0] ep;
    logic       probe;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic cr, en, pe, input logic [7:0] ph, pm, input logic am, ah);
    int  ht, hu, mt, mu;
    bit  legal, tick;
    if (cr) begin
      mh = 0; mm = 0; ms = 0; mp = 0; mpul = '0;
      return;
    end
    ht = int'(ph[7:4]); hu = int'(ph[3:0]); mt = int'(pm[7:4]); mu = int'(pm[3:0]);
    legal = (hu <= 9) && (mu <= 9) && (mt <= 5) && (ht * 10 + hu <= 23);
    tick  = en && (mp == TD - 1);
    mpul  = {4'b0000, pe && !legal};
    if (pe && legal) begin
      mh = ht * 10 + hu; mm = mt * 10 + mu; ms = 0; mp = 0;
    end else begin
      if (en) mp = (mp + 1) % TD;
      if (am || ah) begin
        if (am) mm = (mm + 1) % 60;
        if (ah) mh = (mh + 1) % 24;
      end else if (tick) begin
        mpul[4] = 1'b1;
        ms++;
        if (ms == 60) begin
          ms = 0; mpul[3] = 1'b1; mm++;
          if (mm == 60) begin
            mm = 0; mpul[2] = 1'b1; mh++;
            if (mh == 24) begin
              mh = 0; mpul[1] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic cyc(input logic cr, en, pe, input logic [7:0] ph, pm, input logic am, ah);
    logic [28:0] got, exp;
    CR = cr; EN = en; PE = pe; pre_hour = ph; pre_min = pm; adj_min = am; adj_hour = ah;
    model_step(cr, en, pe, ph, pm, am, ah);
    sb.push_back({bcd(mh), bcd(mm), bcd(ms), mpul});
    @(posedge CP);
    #1;
    got = {show_hour, show_min, show_sec, sec_tick, min_carry, hour_chime, day_carry, load_err};
    exp = sb.pop_front();
    check("cycle_vs_model", {3'b0, got}, {3'b0, exp});
  endtask

  task automatic probe_first_tick();
    int k;
    k = 0;
    for (int j = 1; j <= 5 * TD && k == 0; j++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      if (sec_tick === 1'b1) k = j;
    end
    check("first_tick_latency", k, TD);
  endtask

  initial begin
    CR = 1'b0; EN = 1'b0; PE = 1'b0; pre_hour = '0; pre_min = '0; adj_min = 1'b0; adj_hour = 1'b0;

    //            cr  en  pe  ph     pm     am  ah  n    eh     em     es     ep        probe
    tbl.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 1,   8'h00, 8'h00, 8'h00, 5'b00000, 0});
    tbl.push_back('{0, 1, 1, 8'h15, 8'h37, 0, 0, 1,   8'h15, 8'h37, 8'h00, 5'b00000, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 0, 0, 9,   8'h15, 8'h37, 8'h02, 5'b00000, 0});
    tbl.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 2,   8'h00, 8'h00, 8'h00, 5'b00000, 1});
    tbl.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0, 1,   8'h00, 8'h00, 8'h00, 5'b00000, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 0, 0, 40,  8'h00, 8'h00, 8'h10, 5'b10000, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 0, 0, 200, 8'h00, 8'h01, 8'h00, 5'b11000, 0});
    tbl.push_back('{0, 1, 1, 8'h23, 8'h59, 0, 0, 1,   8'h23, 8'h59, 8'h00, 5'b00000, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 0, 0, 236, 8'h23, 8'h59, 8'h59, 5'b10000, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 0, 0, 4,   8'h00, 8'h00, 8'h00, 5'b11110, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 0, 0, 1,   8'h00, 8'h00, 8'h00, 5'b00000, 0});
    tbl.push_back('{0, 1, 1, 8'h24, 8'h00, 0, 0, 1,   8'h00, 8'h00, 8'h00, 5'b00001, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 0, 0, 1,   8'h00, 8'h00, 8'h00, 5'b00000, 0});
    tbl.push_back('{0, 1, 1, 8'h12, 8'h5A, 0, 0, 1,   8'h00, 8'h00, 8'h01, 5'b10001, 0});
    tbl.push_back('{0, 0, 1, 8'h05, 8'h59, 0, 0, 1,   8'h05, 8'h59, 8'h00, 5'b00000, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 8'h00, 1, 0, 1,   8'h05, 8'h00, 8'h00, 5'b00000, 0});
    tbl.push_back('{0, 0, 1, 8'h23, 8'h10, 0, 0, 1,   8'h23, 8'h10, 8'h00, 5'b00000, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 8'h00, 0, 1, 1,   8'h00, 8'h10, 8'h00, 5'b00000, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 8'h00, 1, 1, 1,   8'h01, 8'h11, 8'h00, 5'b00000, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 8'h00, 1, 0, 3,   8'h01, 8'h14, 8'h00, 5'b00000, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 0, 0, 3,   8'h01, 8'h14, 8'h00, 5'b00000, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 1, 0, 1,   8'h01, 8'h15, 8'h00, 5'b00000, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 0, 0, 4,   8'h01, 8'h15, 8'h01, 5'b10000, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 0, 0, 2,   8'h01, 8'h15, 8'h01, 5'b00000, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 8'h00, 0, 0, 10,  8'h01, 8'h15, 8'h01, 5'b00000, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 0, 0, 2,   8'h01, 8'h15, 8'h02, 5'b10000, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 0, 0, 2,   8'h01, 8'h15, 8'h02, 5'b00000, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 8'h00, 0, 0, 1,   8'h00, 8'h00, 8'h00, 5'b00000, 1});
    tbl.push_back('{0, 1, 1, 8'h09, 8'h59, 0, 0, 1,   8'h09, 8'h59, 8'h00, 5'b00000, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 0, 0, 240, 8'h10, 8'h00, 8'h00, 5'b11100, 0});
    tbl.push_back('{0, 1, 1, 8'h19, 8'h59, 0, 0, 1,   8'h19, 8'h59, 8'h00, 5'b00000, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 0, 0, 240, 8'h20, 8'h00, 8'h00, 5'b11100, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].n; c++)
        cyc(tbl[i].cr, tbl[i].en, tbl[i].pe, tbl[i].ph, tbl[i].pm, tbl[i].am, tbl[i].ah);
      check($sformatf("row%0d", i),
            {3'b0, show_hour, show_min, show_sec, sec_tick, min_carry, hour_chime, day_carry, load_err},
            {3'b0, tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].ep});
      if (tbl[i].probe) probe_first_tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
